// File: rtl/pwm_quad_ctrl.sv
// pwm_quad_ctrl: Avalon-MM slave with NUM_CH shared-period PWM channels and an x4 quadrature decoder.
// Define QUAD_FILTER_EN to insert a 4-sample glitch filter between the synchroniser and the decoder.
module pwm_quad_ctrl #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned POS_W  = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [3:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm_out_new_signal,
  input  logic [1:0]        encoder_in_new_signal,
  output logic              irq
);

  localparam logic [3:0]  AddrCtrl   = 4'd0;
  localparam logic [3:0]  AddrPeriod = 4'd1;
  localparam logic [3:0]  AddrStatus = 4'd2;
  localparam logic [3:0]  AddrPos    = 4'd3;
  localparam int unsigned DutyBase   = 4;

  // Register file
  logic             r_en;
  logic             r_irq_en;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty [NUM_CH];
  logic             r_err;
  logic [POS_W-1:0] r_pos;
  logic [31:0]      r_rdata;

  // PWM engine
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_act_period;
  logic [CNT_W-1:0]  r_act_duty [NUM_CH];
  logic              r_running;
  logic [NUM_CH-1:0] r_pwm;

  // Encoder path
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_prev;

  logic             w_wr_ctrl;
  logic             w_wr_period;
  logic             w_wr_status;
  logic             w_pos_clr;
  logic             w_err_clr;
  logic             w_run;
  logic             w_wrap;
  logic             w_load;
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W-1:0] w_eff_period;
  logic [CNT_W-1:0] w_eff_duty [NUM_CH];
  logic [1:0]       w_dec;
  logic [1:0]       w_step;
  logic             w_inc;
  logic             w_dn;
  logic             w_illegal;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_unused_wdata = ^avs_writedata;

  assign w_wr_ctrl   = avs_write && (avs_address == AddrCtrl);
  assign w_wr_period = avs_write && (avs_address == AddrPeriod);
  assign w_wr_status = avs_write && (avs_address == AddrStatus);
  assign w_pos_clr   = w_wr_ctrl && avs_writedata[1];
  assign w_err_clr   = w_wr_status && avs_writedata[0];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_period <= '0;
      for (int n = 0; n < int'(NUM_CH); n++) begin
        r_duty[n] <= '0;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= avs_writedata[0];
        r_irq_en <= avs_writedata[2];
      end
      if (w_wr_period) begin
        r_period <= avs_writedata[CNT_W-1:0];
      end
      for (int n = 0; n < int'(NUM_CH); n++) begin
        if (avs_write && (avs_address == 4'(DutyBase + n))) begin
          r_duty[n] <= avs_writedata[CNT_W-1:0];
        end
      end
    end
  end

  // While idle (or on the first running cycle) the live registers are used directly;
  // once running, the shadow copies hold until the period boundary.
  assign w_run     = r_en && (r_period != '0);
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_wrap    = w_cnt_inc >= {1'b0, w_eff_period};
  assign w_load    = !w_run || !r_running || w_wrap;

  always_comb begin
    w_eff_period = r_running ? r_act_period : r_period;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      w_eff_duty[n] = r_running ? r_act_duty[n] : r_duty[n];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_cnt        <= '0;
      r_act_period <= '0;
      r_running    <= 1'b0;
      r_pwm        <= '0;
      for (int n = 0; n < int'(NUM_CH); n++) begin
        r_act_duty[n] <= '0;
      end
    end else begin
      r_running <= w_run;
      if (!w_run || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc[CNT_W-1:0];
      end
      if (w_load) begin
        r_act_period <= r_period;
        for (int n = 0; n < int'(NUM_CH); n++) begin
          r_act_duty[n] <= r_duty[n];
        end
      end
      for (int n = 0; n < int'(NUM_CH); n++) begin
        r_pwm[n] <= w_run && (r_cnt < w_eff_duty[n]);
      end
    end
  end

`ifdef QUAD_FILTER_EN
  logic [1:0] r_hist0;
  logic [1:0] r_hist1;
  logic [1:0] r_hist2;
  logic       w_agree;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_hist0 <= '0;
      r_hist1 <= '0;
      r_hist2 <= '0;
    end else begin
      r_hist0 <= r_sync2;
      r_hist1 <= r_hist0;
      r_hist2 <= r_hist1;
    end
  end

  // The last accepted value lives in r_prev, so holding the filter output is just reusing it.
  assign w_agree = (r_sync2 == r_hist0) && (r_hist0 == r_hist1) && (r_hist1 == r_hist2);
  assign w_dec   = w_agree ? r_sync2 : r_prev;
`else
  assign w_dec = r_sync2;
`endif

  function automatic logic [1:0] gray_idx(input logic [1:0] ba);
    case (ba)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  assign w_step    = gray_idx(w_dec) - gray_idx(r_prev);
  assign w_inc     = (w_step == 2'd1);
  assign w_dn      = (w_step == 2'd3);
  assign w_illegal = (w_step == 2'd2);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_pos   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= encoder_in_new_signal;
      r_sync2 <= r_sync1;
      r_prev  <= w_dec;
      if (w_pos_clr) begin
        r_pos <= '0;
      end else if (w_inc) begin
        r_pos <= r_pos + {{(POS_W-1){1'b0}}, 1'b1};
      end else if (w_dn) begin
        r_pos <= r_pos - {{(POS_W-1){1'b0}}, 1'b1};
      end
      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      AddrCtrl:   w_rdata = {29'b0, r_irq_en, 1'b0, r_en};
      AddrPeriod: w_rdata[CNT_W-1:0] = r_period;
      AddrStatus: w_rdata[0] = r_err;
      AddrPos:    w_rdata = 32'(signed'(r_pos));
      default: begin
        for (int n = 0; n < int'(NUM_CH); n++) begin
          if (avs_address == 4'(DutyBase + n)) begin
            w_rdata[CNT_W-1:0] = r_duty[n];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rdata <= '0;
    end else if (avs_read) begin
      r_rdata <= w_rdata;
    end
  end

  assign avs_readdata       = r_rdata;
  assign pwm_out_new_signal = r_pwm;
  assign irq                = r_err && r_irq_en;

endmodule

// File: tb/tb_pwm_quad_ctrl.sv
// tb_pwm_quad_ctrl: directed and randomized bench for pwm_quad_ctrl with an in-bench reference model.
module tb_pwm_quad_ctrl;

  localparam int NCH = 2;
`ifdef QUAD_FILTER_EN
  localparam int Lat = 6;
`else
  localparam int Lat = 3;
`endif

  logic            clk_clk = 1'b0;
  logic            reset_reset = 1'b1;
  logic [3:0]      avs_address = '0;
  logic            avs_write = 1'b0;
  logic [31:0]     avs_writedata = '0;
  logic            avs_read = 1'b0;
  logic [31:0]     avs_readdata;
  logic [NCH-1:0]  pwm;
  logic [1:0]      enc = 2'b00;
  logic            irq;

  int checks = 0;
  int errors = 0;

  pwm_quad_ctrl #(.NUM_CH(NCH), .CNT_W(16), .POS_W(32)) dut (
    .clk_clk              (clk_clk),
    .reset_reset          (reset_reset),
    .avs_address          (avs_address),
    .avs_write            (avs_write),
    .avs_writedata        (avs_writedata),
    .avs_read             (avs_read),
    .avs_readdata         (avs_readdata),
    .pwm_out_new_signal   (pwm),
    .encoder_in_new_signal(enc),
    .irq                  (irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit             m_en, m_irq_en, m_err, m_run_prev;
  bit [15:0]      m_period;
  bit [15:0]      m_duty [NCH];
  bit [31:0]      m_pos, m_rdata;
  bit [NCH-1:0]   m_pwm;
  int             m_phase, m_cur_per;
  int             m_cur_duty [NCH];
  bit [1:0]       m_hist [5];
  bit [1:0]       m_f;

  function automatic logic [1:0] fwd(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return {29'b0, m_irq_en, 1'b0, m_en};
      4'd1:    return {16'b0, m_period};
      4'd2:    return {31'b0, m_err};
      4'd3:    return m_pos;
      4'd4:    return {16'b0, m_duty[0]};
      4'd5:    return {16'b0, m_duty[1]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk_clk) begin : model
    bit [1:0] o;
    bit [1:0] n;
    bit       run;
    if (reset_reset) begin
      m_en = 0; m_irq_en = 0; m_err = 0; m_run_prev = 0; m_period = 0;
      m_pos = 0; m_rdata = 0; m_pwm = 0; m_phase = 0; m_cur_per = 0; m_f = 0;
      for (int i = 0; i < NCH; i++) begin
        m_duty[i] = 0;
        m_cur_duty[i] = 0;
      end
      for (int i = 0; i < 5; i++) m_hist[i] = 0;
    end else begin
      if (avs_read) m_rdata = model_read(avs_address);
      // PWM: a period's period/duty are the register values seen when it starts from idle,
      // or on the last cycle of the preceding period.
      run = m_en && (m_period != 0);
      if (!run) begin
        m_pwm = 0;
        m_phase = 0;
        m_run_prev = 0;
      end else begin
        if (!m_run_prev) begin
          m_cur_per = int'(m_period);
          for (int i = 0; i < NCH; i++) m_cur_duty[i] = int'(m_duty[i]);
        end
        for (int i = 0; i < NCH; i++) m_pwm[i] = (m_phase < m_cur_duty[i]);
        m_phase++;
        if (m_phase >= m_cur_per) begin
          m_phase = 0;
          m_cur_per = int'(m_period);
          for (int i = 0; i < NCH; i++) m_cur_duty[i] = int'(m_duty[i]);
        end
        m_run_prev = 1;
      end
      // Encoder: m_hist[i] = pin value sampled i+1 edges ago.
`ifdef QUAD_FILTER_EN
      o = m_f;
      if (m_hist[1] == m_hist[2] && m_hist[2] == m_hist[3] && m_hist[3] == m_hist[4])
        n = m_hist[1];
      else
        n = m_f;
      m_f = n;
`else
      o = m_hist[2];
      n = m_hist[1];
`endif
      for (int i = 4; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = enc;
      if (avs_write && avs_address == 4'd0 && avs_writedata[1]) m_pos = 0;
      else if (n == fwd(o)) m_pos = m_pos + 32'd1;
      else if (o == fwd(n)) m_pos = m_pos - 32'd1;
      if ((o ^ n) == 2'b11) m_err = 1;
      else if (avs_write && avs_address == 4'd2 && avs_writedata[0]) m_err = 0;
      if (avs_write) begin
        case (avs_address)
          4'd0: begin m_en = avs_writedata[0]; m_irq_en = avs_writedata[2]; end
          4'd1: m_period = avs_writedata[15:0];
          4'd4: m_duty[0] = avs_writedata[15:0];
          4'd5: m_duty[1] = avs_writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk_clk) begin
    check("pwm_model", 32'(pwm), 32'(m_pwm));
    check("irq_model", 32'(irq), 32'(m_err && m_irq_en));
    check("rdata_model", avs_readdata, m_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    avs_read = 1'b1; avs_address = a;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic count_high(input int ch, input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk_clk);
      c += int'(pwm[ch]);
    end
  endtask

  task automatic enc_seq(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] s3);
    @(negedge clk_clk); enc = s0; idle(7);
    @(negedge clk_clk); enc = s1; idle(7);
    @(negedge clk_clk); enc = s2; idle(7);
    @(negedge clk_clk); enc = s3; idle(7);
    idle(8);
  endtask

  initial begin
    logic [31:0] d;
    int          c, c1, c2, hold, r;
    logic [3:0]  a;

    repeat (3) @(negedge clk_clk);
    check("rst_rdata", avs_readdata, 32'h0);
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_reset = 1'b0;
    rd(4'd3, d); check("rst_pos", d, 32'h0);

    // Basic duty cycle
    wr(4'd1, 32'd10); wr(4'd4, 32'd3); wr(4'd0, 32'd1);
    idle(12);
    count_high(0, 10, c); check("duty3_per10", 32'(c), 32'd3);
    count_high(0, 20, c); check("duty3_per20", 32'(c), 32'd6);

    // Duty extremes on channel 1
    wr(4'd5, 32'd0);  idle(12); count_high(1, 10, c); check("duty0", 32'(c), 32'd0);
    wr(4'd5, 32'd10); idle(12); count_high(1, 10, c); check("duty_eq_per", 32'(c), 32'd10);
    wr(4'd5, 32'd15); idle(12); count_high(1, 10, c); check("duty_gt_per", 32'(c), 32'd10);
    wr(4'd1, 32'd0);  idle(3);
    count_high(0, 10, c); count_high(1, 10, c1);
    check("period0", 32'(c + c1), 32'd0);

    // Double buffering: DUTY0 written while the counter is at 5
    wr(4'd0, 32'd0); wr(4'd1, 32'd10); wr(4'd4, 32'd3); wr(4'd0, 32'd1);
    c1 = 0; c2 = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk_clk);
      if (j <= 10) c1 += int'(pwm[0]); else c2 += int'(pwm[0]);
      if (j == 5) begin avs_write = 1'b1; avs_address = 4'd4; avs_writedata = 32'd7; end
      if (j == 6) avs_write = 1'b0;
    end
    check("dbuf_cur", 32'(c1), 32'd3);
    check("dbuf_next", 32'(c2), 32'd7);

    // Quadrature counting
    wr(4'd0, 32'd2);
    enc_seq(2'b01, 2'b11, 2'b10, 2'b00);
    rd(4'd3, d); check("pos_fwd", d, 32'd4);
    wr(4'd0, 32'd2);
    enc_seq(2'b10, 2'b11, 2'b01, 2'b00);
    rd(4'd3, d); check("pos_rev", d, 32'hFFFF_FFFC);

    // Illegal transition and W1C
    wr(4'd0, 32'd4);
    @(negedge clk_clk); enc = 2'b11; idle(10);
    check("illegal_irq", 32'(irq), 32'd1);
    rd(4'd2, d); check("illegal_err", d, 32'd1);
    rd(4'd3, d); check("illegal_pos", d, 32'hFFFF_FFFC);
    wr(4'd2, 32'd1);
    check("w1c_irq", 32'(irq), 32'd0);
    rd(4'd2, d); check("w1c_err", d, 32'd0);
    @(negedge clk_clk); enc = 2'b10; idle(8);
    @(negedge clk_clk); enc = 2'b00; idle(8);
    rd(4'd3, d); check("pos_back", d, 32'hFFFF_FFFE);

    // pos_clr lands on the same edge as a +1 decode
    @(negedge clk_clk); enc = 2'b01;
    repeat (Lat - 1) @(negedge clk_clk);
    avs_write = 1'b1; avs_address = 4'd0; avs_writedata = 32'd2;
    @(negedge clk_clk); avs_write = 1'b0;
    idle(10);
    rd(4'd3, d); check("clr_wins", d, 32'd0);

    // Pin-to-POSITION latency
    @(negedge clk_clk); enc = 2'b11;
    repeat (Lat - 1) @(negedge clk_clk);
    avs_read = 1'b1; avs_address = 4'd3;
    @(negedge clk_clk); check("lat_before", avs_readdata, 32'd0);
    @(negedge clk_clk); check("lat_after", avs_readdata, 32'd1);
    avs_read = 1'b0;

`ifdef QUAD_FILTER_EN
    @(negedge clk_clk); enc = 2'b10;
    idle(1);
    @(negedge clk_clk); enc = 2'b11;
    idle(12);
    rd(4'd3, d); check("glitch_reject", d, 32'd1);
    rd(4'd2, d); check("glitch_no_err", d, 32'd0);
`endif

    // Randomized traffic with one mid-run reset
    hold = 3;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_clk);
      if (i == 2000) reset_reset = 1'b1;
      if (i == 2003) reset_reset = 1'b0;
      avs_write = 1'b0;
      avs_read = 1'b0;
      a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      r = int'($urandom_range(0, 9));
      avs_address = a;
      if (r < 3) begin
        avs_write = 1'b1;
        case (a)
          4'd0: begin
            d = '0;
            d[0] = ($urandom_range(0, 4) != 0);
            d[1] = ($urandom_range(0, 15) == 0);
            d[2] = 1'($urandom_range(0, 1));
          end
          4'd1:       d = $urandom_range(0, 12);
          4'd4, 4'd5: d = $urandom_range(0, 15);
          default:    d = $urandom;
        endcase
        avs_writedata = d;
      end else if (r < 6) begin
        avs_read = 1'b1;
      end
      if (hold == 0) begin
        r = int'($urandom_range(0, 19));
        if (r < 9) enc = fwd(enc);
        else if (r < 18) enc = rev(enc);
        else enc = ~enc;
        hold = int'($urandom_range(1, 9));
      end else begin
        hold--;
      end
    end
    @(negedge clk_clk);
    avs_write = 1'b0;
    avs_read = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
